width_gearbox: RTL and testbench

Parametrised streaming width converter that repacks an IN_W-bit input stream into an OUT_W-bit output stream for any width ratio, up or down, with valid/ready backpressure on both sides. It generalises the fixed 16-to-24-bit pixel repacker used between the DDR read path and the RGB consumers. It also adds a last-beat flush that emits a zero-padded residual word. Packing is LSB-first: the earliest input bits land in the low bits of the output word.

---
 rtl/width_gearbox.sv | 114 +++++++++++
 tb/tb_width_gearbox.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/width_gearbox.sv
// -----------------------------------------------------------------------------
// width_gearbox
//
// Streaming width converter that repacks an IN_W-bit input stream into an
// OUT_W-bit output stream, LSB-first: the earliest input bits occupy the low
// bits of each output word. Any ratio, up or down, is supported. A beat
// flagged with s_last flushes the residue as one zero-padded final word that
// carries m_last. A packet that fills its final word exactly ends on that
// full word, with no extra empty word.
//
// Ports
//   s_clk    in   clock, rising edge
//   s_rst_n  in   asynchronous active-low reset
//   s_data   in   [IN_W-1:0]  input word
//   s_valid  in   input word present
//   s_last   in   input word closes the packet (qualified by s_valid)
//   s_ready  out  input accepted this cycle (depends on registers only)
//   m_data   out  [OUT_W-1:0] output word
//   m_valid  out  output word present
//   m_last   out  final, possibly zero-padded, word of the packet
//   m_ready  in   downstream accepts the output word this cycle
// -----------------------------------------------------------------------------
module width_gearbox #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 24,
  parameter int CNT_W = $clog2(IN_W + OUT_W + 1)
) (
  input  logic             s_clk,
  input  logic             s_rst_n,
  input  logic [IN_W-1:0]  s_data,
  input  logic             s_valid,
  input  logic             s_last,
  output logic             s_ready,
  output logic [OUT_W-1:0] m_data,
  output logic             m_valid,
  output logic             m_last,
  input  logic             m_ready
);

  localparam int BUF_W = IN_W + OUT_W;
  localparam logic [CNT_W-1:0] OUT_CNT = CNT_W'(OUT_W);
  localparam logic [CNT_W-1:0] IN_CNT  = CNT_W'(IN_W);

  // Valid bits sit in data_buf_q[cnt_q-1:0]; everything above is kept zero,
  // so a new word can simply be OR-ed in above the residue.
  logic [BUF_W-1:0] data_buf_q, data_buf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             draining_q, draining_d;

  logic             push;
  logic             pop;
  logic [BUF_W-1:0] base;
  logic [CNT_W-1:0] cb;
  logic [BUF_W-1:0] s_data_ext;

  assign s_data_ext = {{OUT_W{1'b0}}, s_data};

  // Accept a word only while the buffer can hold it even without a pop in the
  // same cycle; this keeps s_ready free of any path from m_ready.
  assign s_ready = !draining_q && (cnt_q <= OUT_CNT);
  assign m_valid = (cnt_q >= OUT_CNT) || (draining_q && (cnt_q != '0));
  assign m_data  = data_buf_q[OUT_W-1:0];
  assign m_last  = draining_q && (cnt_q <= OUT_CNT);

  always_comb begin
    // NOTE: every variable gets a default before any branch so no path leaves
    // it unassigned, which would otherwise infer a latch.
    push       = s_valid && s_ready;
    pop        = m_valid && m_ready;
    base       = data_buf_q;
    cb         = cnt_q;
    data_buf_d = data_buf_q;
    cnt_d      = cnt_q;
    draining_d = draining_q;

    // Retire the output word first; a padded final word may hold fewer than
    // OUT_W valid bits, in which case the residue becomes empty.
    if (pop) begin
      base = data_buf_q >> OUT_W;
      cb   = (cnt_q > OUT_CNT) ? (cnt_q - OUT_CNT) : '0;
    end

    // A same-cycle push lands directly above the post-pop residue.
    data_buf_d = base;
    cnt_d      = cb;
    if (push) begin
      data_buf_d = base | (s_data_ext << cb);
      cnt_d      = cb + IN_CNT;
    end

    // Setting and clearing are mutually exclusive: push needs !draining,
    // m_last needs draining.
    if (push && s_last) begin
      draining_d = 1'b1;
    end else if (pop && m_last) begin
      draining_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge s_clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      data_buf_q <= '0;
      cnt_q      <= '0;
      draining_q <= 1'b0;
    end else begin
      data_buf_q <= data_buf_d;
      cnt_q      <= cnt_d;
      draining_q <= draining_d;
    end
  end

endmodule

// File: tb/tb_width_gearbox.sv
// -----------------------------------------------------------------------------
// tb_width_gearbox
//
// Drives a 16->24 instance (u_up) and a 24->16 instance (u_dn) through a table
// of per-cycle vectors with hand-computed expected outputs, then a mid-packet
// reset sequence and randomly throttled packet streams checked against a
// bitstream model.
// -----------------------------------------------------------------------------
module tb_width_gearbox;

  logic clk;
  logic rst_n;

  // 16 -> 24 instance
  logic [15:0] up_s_data;
  logic        up_s_valid, up_s_last, up_s_ready;
  logic [23:0] up_m_data;
  logic        up_m_valid, up_m_last, up_m_ready;

  // 24 -> 16 instance
  logic [23:0] dn_s_data;
  logic        dn_s_valid, dn_s_last, dn_s_ready;
  logic [15:0] dn_m_data;
  logic        dn_m_valid, dn_m_last, dn_m_ready;

  int n_checks = 0;
  int n_fail   = 0;

  width_gearbox #(.IN_W(16), .OUT_W(24)) u_up (
    .s_clk   (clk),
    .s_rst_n (rst_n),
    .s_data  (up_s_data),
    .s_valid (up_s_valid),
    .s_last  (up_s_last),
    .s_ready (up_s_ready),
    .m_data  (up_m_data),
    .m_valid (up_m_valid),
    .m_last  (up_m_last),
    .m_ready (up_m_ready)
  );

  width_gearbox #(.IN_W(24), .OUT_W(16)) u_dn (
    .s_clk   (clk),
    .s_rst_n (rst_n),
    .s_data  (dn_s_data),
    .s_valid (dn_s_valid),
    .s_last  (dn_s_last),
    .s_ready (dn_s_ready),
    .m_data  (dn_m_data),
    .m_valid (dn_m_valid),
    .m_last  (dn_m_last),
    .m_ready (dn_m_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          sel;       // 0: u_up, 1: u_dn
    logic [31:0] s_data;
    bit          s_valid;
    bit          s_last;
    bit          m_ready;
    bit          e_s_ready;
    bit          e_m_valid;
    logic [31:0] e_m_data;
    bit          e_m_last;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit sel, logic [31:0] d, bit v, bit l, bit mr,
                              bit er, bit ev, logic [31:0] ed, bit el);
    vec_t r;
    r.sel = sel; r.s_data = d; r.s_valid = v; r.s_last = l; r.m_ready = mr;
    r.e_s_ready = er; r.e_m_valid = ev; r.e_m_data = ed; r.e_m_last = el;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit sel, input logic [31:0] d, input bit v, input bit l, input bit mr);
    if (sel) begin
      dn_s_data = d[23:0]; dn_s_valid = v; dn_s_last = l; dn_m_ready = mr;
    end else begin
      up_s_data = d[15:0]; up_s_valid = v; up_s_last = l; up_m_ready = mr;
    end
  endtask

  task automatic get(input bit sel, output bit rdy, output bit mv,
                     output logic [31:0] md, output bit ml);
    if (sel) begin
      rdy = dn_s_ready; mv = dn_m_valid; md = {16'h0, dn_m_data}; ml = dn_m_last;
    end else begin
      rdy = up_s_ready; mv = up_m_valid; md = {8'h0, up_m_data}; ml = up_m_last;
    end
  endtask

  // Random packets on one instance; the expected output is the concatenated
  // input bitstream, zero-padded to a whole output word at every packet end.
  task automatic run_random(input bit sel, input int n_pkts);
    int          in_w;
    int          out_w;
    logic [31:0] in_d[$];
    bit          in_l[$];
    logic [31:0] exp_d[$];
    bit          exp_l[$];
    bit          bq[$];
    logic [31:0] w;
    bit          v;
    bit          mr;
    bit          rdy, mv, ml;
    logic [31:0] md;
    int          budget;
    in_w  = sel ? 24 : 16;
    out_w = sel ? 16 : 24;
    for (int p = 0; p < n_pkts; p++) begin
      int nw;
      nw = $urandom_range(1, 20);
      bq.delete();
      for (int k = 0; k < nw; k++) begin
        w = $urandom & ((32'h1 << in_w) - 1);
        in_d.push_back(w);
        in_l.push_back(k == nw - 1);
        for (int b = 0; b < in_w; b++) bq.push_back(w[b]);
      end
      while (bq.size() % out_w != 0) bq.push_back(1'b0);
      for (int c = 0; c < bq.size() / out_w; c++) begin
        w = '0;
        for (int b = 0; b < out_w; b++) w[b] = bq[c * out_w + b];
        exp_d.push_back(w);
        exp_l.push_back(c == bq.size() / out_w - 1);
      end
    end

    v = 1'b0;
    budget = 0;
    while (exp_d.size() > 0 && budget < 5000) begin
      @(negedge clk);
      // Once raised, s_valid and the word are held until accepted.
      if (!v && in_d.size() > 0 && $urandom_range(0, 3) != 0) v = 1'b1;
      mr = ($urandom_range(0, 2) != 0);
      drive(sel, v ? in_d[0] : 32'h0, v, v ? in_l[0] : 1'b0, mr);
      #1;
      get(sel, rdy, mv, md, ml);
      if (mv && mr) begin
        check(sel ? "dn_rnd_data" : "up_rnd_data", md, exp_d[0]);
        check(sel ? "dn_rnd_last" : "up_rnd_last", {31'h0, ml}, {31'h0, exp_l[0]});
        void'(exp_d.pop_front());
        void'(exp_l.pop_front());
      end
      if (v && rdy) begin
        void'(in_d.pop_front());
        void'(in_l.pop_front());
        v = 1'b0;
      end
      budget++;
    end
    check(sel ? "dn_rnd_words_left" : "up_rnd_words_left", exp_d.size(), 0);
    @(negedge clk);
    drive(sel, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    bit          rdy, mv, ml;
    logic [31:0] md;

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    #1;
    get(0, rdy, mv, md, ml);
    check("reset_m_valid", {31'h0, mv}, 0);
    check("reset_m_last",  {31'h0, ml}, 0);
    check("reset_m_data",  md, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    get(0, rdy, mv, md, ml);
    check("reset_s_ready", {31'h0, rdy}, 1);

    // Up 16->24: three words, m_ready high.
    vecs.push_back(mk(0, 'h2211, 1, 0, 1,  1, 0, 'h0,      0));
    vecs.push_back(mk(0, 'h4433, 1, 0, 1,  1, 0, 'h2211,   0));
    vecs.push_back(mk(0, 'h6655, 1, 0, 1,  0, 1, 'h332211, 0));
    vecs.push_back(mk(0, 'h6655, 1, 0, 1,  1, 0, 'h44,     0));
    vecs.push_back(mk(0, 'h0,    0, 0, 1,  1, 1, 'h665544, 0));
    vecs.push_back(mk(0, 'h0,    0, 0, 1,  1, 0, 'h0,      0));
    // Up 16->24 flush: s_last on the second word gives a padded final word.
    vecs.push_back(mk(0, 'h2211, 1, 0, 1,  1, 0, 'h0,      0));
    vecs.push_back(mk(0, 'h4433, 1, 1, 1,  1, 0, 'h2211,   0));
    vecs.push_back(mk(0, 'h0,    0, 0, 1,  0, 1, 'h332211, 0));
    vecs.push_back(mk(0, 'h0,    0, 0, 1,  0, 1, 'h44,     1));
    vecs.push_back(mk(0, 'h0,    0, 0, 1,  1, 0, 'h0,      0));
    // Backpressure: m_ready low for 5 cycles with 0x332211 pending.
    vecs.push_back(mk(0, 'h2211, 1, 0, 0,  1, 0, 'h0,      0));
    vecs.push_back(mk(0, 'h4433, 1, 0, 0,  1, 0, 'h2211,   0));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(0, 'h6655, 1, 0, 0,  0, 1, 'h332211, 0));
    vecs.push_back(mk(0, 'h6655, 1, 0, 1,  0, 1, 'h332211, 0));
    vecs.push_back(mk(0, 'h6655, 1, 0, 1,  1, 0, 'h44,     0));
    vecs.push_back(mk(0, 'h0,    0, 0, 1,  1, 1, 'h665544, 0));
    vecs.push_back(mk(0, 'h0,    0, 0, 1,  1, 0, 'h0,      0));
    // Down 24->16: 48 bits end on a full word with m_last, no padding word.
    vecs.push_back(mk(1, 'h332211, 1, 0, 1,  1, 0, 'h0,    0));
    vecs.push_back(mk(1, 'h665544, 1, 1, 1,  0, 1, 'h2211, 0));
    vecs.push_back(mk(1, 'h665544, 1, 1, 1,  1, 0, 'h33,   0));
    vecs.push_back(mk(1, 'h0,      0, 0, 1,  0, 1, 'h4433, 0));
    vecs.push_back(mk(1, 'h0,      0, 0, 1,  0, 1, 'h6655, 1));
    vecs.push_back(mk(1, 'h0,      0, 0, 1,  1, 0, 'h0,    0));

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].sel, vecs[i].s_data, vecs[i].s_valid, vecs[i].s_last, vecs[i].m_ready);
      #1;
      get(vecs[i].sel, rdy, mv, md, ml);
      check($sformatf("vec%0d_s_ready", i), {31'h0, rdy}, {31'h0, vecs[i].e_s_ready});
      check($sformatf("vec%0d_m_valid", i), {31'h0, mv},  {31'h0, vecs[i].e_m_valid});
      check($sformatf("vec%0d_m_data", i),  md,           vecs[i].e_m_data);
      check($sformatf("vec%0d_m_last", i),  {31'h0, ml},  {31'h0, vecs[i].e_m_last});
    end
    @(negedge clk);
    drive(1, 0, 0, 0, 0);

    // Mid-packet reset: cnt = 16 and draining on u_up, then reset and restart.
    drive(0, 'h2211, 1, 1, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0);
    #1;
    get(0, rdy, mv, md, ml);
    check("pre_rst_m_valid", {31'h0, mv}, 1);
    check("pre_rst_m_last",  {31'h0, ml}, 1);
    check("pre_rst_s_ready", {31'h0, rdy}, 0);
    rst_n = 1'b0;
    #1;
    get(0, rdy, mv, md, ml);
    check("mid_rst_m_valid", {31'h0, mv}, 0);
    check("mid_rst_m_last",  {31'h0, ml}, 0);
    check("mid_rst_s_ready", {31'h0, rdy}, 1);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 'h4433, 1, 1, 1);
    #1;
    get(0, rdy, mv, md, ml);
    check("post_rst_m_valid", {31'h0, mv}, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 1);
    #1;
    get(0, rdy, mv, md, ml);
    check("post_rst_m_data",  md, 'h4433);
    check("post_rst_m_last",  {31'h0, ml}, 1);
    @(negedge clk);
    #1;
    get(0, rdy, mv, md, ml);
    check("post_rst_idle", {31'h0, mv}, 0);
    drive(0, 0, 0, 0, 0);

    run_random(0, 6);
    run_random(1, 6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
